mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter that shares a single 4-to-1 one-bit mux between four requesters. It grants one requester at a time, holds the grant until release, and drives the mux select `S[1:0]` together with a one-hot grant vector. It sits directly in front of the 4-to-1 mux: `sel` connects to `S`, and requester *i* owns mux input `I`*i* while `gnt[i]` is high.

## Interface
Parameters:
- `MAX_HOLD`, default 16: maximum consecutive cycles one grant may be held. Used only when `ARB_TIMEOUT_EN` is defined. Legal range is 2..255.

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `req`  input  4  request vector; bit *i* is requester *i*.
- `done`  input  4  release strobe; bit *i* is honoured only while `gnt[i]`=1.
- `gnt`  output  4  one-hot grant, registered; all zero when idle.
- `sel`  output  2  mux select, registered; the index of the granted requester.
- `busy`  output  1  registered; 1 while any grant is active.
- `timeout`  output  1  registered one-cycle pulse when a grant is revoked by the hold limit. Constant 0 when the feature is compiled out.

## Operation
- Two states:
  - `IDLE`: `gnt`=0.
  - `GRANT`: exactly one bit of `gnt` is set.
- Internal state:
  - Pointer `last[1:0]` holds the index of the most recent winner.
  - Hold counter `hcnt[7:0]`.
- Priority order is `last+1`, `last+2`, `last+3`, `last`, with indices taken modulo 4.
- IDLE transitions:
  - If `req`≠0, the first requester in priority order wins. Next state is GRANT: `gnt[w]`=1, `sel`=w, `last`=w, `hcnt`=1.
  - If `req`=0, stay in IDLE.
- Release condition in GRANT, for holder *h*: `done[h]`=1, or `req[h]`=0, or (with `ARB_TIMEOUT_EN`) `hcnt`==`MAX_HOLD`.
- GRANT transitions:
  - No release: hold the grant and increment `hcnt` (saturating at 255).
  - Release with another request pending (any `req[j]`=1, j≠h): grant back-to-back with no idle cycle. The winner is the first pending requester in priority order starting at h+1, and *h* is excluded even if `req[h]`=1.
  - Release with no other request pending: next state is IDLE, `gnt`=0.
  - `sel` keeps its last value in IDLE.
- `busy` equals `|gnt`.
- `done` bits for non-holders are ignored.
- A request that drops before it is granted is simply not considered.
- Reset values:
  - State = IDLE.
  - `gnt`=4'b0000, `sel`=2'b00, `busy`=0, `timeout`=0.
  - `last`=2'b11, so requester 0 has highest priority after reset.
  - `hcnt`=0.
- Reset asserted mid-grant: the next edge forces all reset values and discards the grant. No release handshake occurs.

## Timing
- `req` to `gnt` latency: 1 cycle from the edge that samples `req`.
- Release latency: `gnt[h]` falls on the edge that samples the release condition. A new `gnt[w]` rises on that same edge, so the handover is one-hot with no overlap.
- `sel` changes on the same edge as `gnt`, so mux output `o` reflects the new owner's input combinationally in the cycle after the grant.
- Minimum grant length: 1 cycle (`done` asserted in the first grant cycle).
- Simultaneous release and new request from the releasing requester: the new request is not served until the other pending requesters have been served once, or until none are pending.
- Timeout: `timeout`=1 for exactly the cycle following revocation. The revoked requester is deprioritised exactly as on a normal release.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - The hold counter enforces `MAX_HOLD`.
  - A grant is revoked after `MAX_HOLD` cycles even when `req[h]`=1 and `done[h]`=0.
  - `timeout` pulses on revocation.
- `ARB_TIMEOUT_EN` undefined:
  - The hold counter and the `MAX_HOLD` comparison are removed.
  - A grant lasts until `done[h]` or `req[h]` deasserts.
  - `timeout` is tied to 0.

## Test plan
- Reset, then `req`=4'b1111 held with `done` pulsed each grant cycle → grants in order 0,1,2,3,0 on consecutive cycles; `sel` sequence is 0,1,2,3,0.
- `req`=4'b0100 for one cycle → `gnt`=4'b0100 and `sel`=2 on the next cycle. Then `req`=0 → `gnt`=0 and `busy`=0 one cycle later, and `sel` stays 2.
- Holder 1 asserts `done[1]` and `req[1]` stays high while `req[3]`=1 → next grant goes to 3. Requester 1 is re-granted only after 3 releases.
- `rst` asserted while `gnt`=4'b1000 → next cycle `gnt`=0, `sel`=0, `busy`=0. A following `req`=4'b1001 grants 0 first.
- With `ARB_TIMEOUT_EN` and `MAX_HOLD`=4: holder 2 keeps `req`=1 and `done`=0 while `req[0]`=1 → `gnt[2]` is high for exactly 4 cycles, then `gnt`=4'b0001 and `timeout` pulses once.
- `done[0]` asserted while `gnt`=4'b0010 → no effect, and requester 1 keeps the grant.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// Requester-side bus for mux4_rr_arbiter: request/release strobes in, grant/select/status out.
// master = requester side, slave = arbiter side.
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  sel,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output sel,
        output busy,
        output timeout
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4-to-1 mux; registered one-hot grant plus select.
// Optional hold limit enabled by defining ARB_TIMEOUT_EN (uses MAX_HOLD).
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input logic              clk,
    input logic              rst,
    mux4_rr_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux4_rr_arbiter: MAX_HOLD must be in 2..255");
    end

    state_t     r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_sel;
    logic       r_busy;
    logic [1:0] r_last;

    logic [3:0] w_cand;
    logic [1:0] w_win;
    logic [1:0] w_idx;
    logic       w_found;
    logic       w_any;
    logic       w_rel_norm;
    logic       w_limit;
    logic       w_release;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_hcnt;
    logic       r_timeout;

    assign w_limit     = (r_hcnt == 8'(MAX_HOLD));
    assign bus.timeout = r_timeout;
`else
    assign w_limit     = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt  = r_gnt;
    assign bus.sel  = r_sel;
    assign bus.busy = r_busy;

    // While granted, r_last is the holder, so masking it out and scanning from
    // r_last+1 gives both the idle order and the "exclude the releaser" order.
    always_comb begin
        w_cand  = (r_state == GRANT) ? (bus.req & ~(4'b0001 << r_last)) : bus.req;
        w_any   = |w_cand;
        w_win   = r_last;
        w_found = 1'b0;
        w_idx   = r_last;
        for (int unsigned k = 1; k <= 4; k++) begin
            w_idx = r_last + 2'(k);
            if (!w_found && w_cand[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
        w_rel_norm = bus.done[r_last] | ~bus.req[r_last];
        w_release  = w_rel_norm | w_limit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_last  <= 2'b11;
`ifdef ARB_TIMEOUT_EN
            r_hcnt    <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= GRANT;
                        r_gnt   <= 4'b0001 << w_win;
                        r_sel   <= w_win;
                        r_last  <= w_win;
                        r_busy  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        r_hcnt  <= 8'd1;
`endif
                    end
                end
                GRANT: begin
                    if (w_release) begin
`ifdef ARB_TIMEOUT_EN
                        if (w_limit && !w_rel_norm) begin
                            r_timeout <= 1'b1;
                        end
`endif
                        if (w_any) begin
                            r_gnt  <= 4'b0001 << w_win;
                            r_sel  <= w_win;
                            r_last <= w_win;
`ifdef ARB_TIMEOUT_EN
                            r_hcnt <= 8'd1;
`endif
                        end else begin
                            r_state <= IDLE;
                            r_gnt   <= '0;
                            r_busy  <= 1'b0;
                        end
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        if (r_hcnt != 8'hFF) begin
                            r_hcnt <= r_hcnt + 8'd1;
                        end
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed per-cycle vectors queue expected outputs,
// a monitor pops and compares one entry after every rising edge.
module tb_mux4_rr_arbiter;

    typedef struct {
        string      name;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       to;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    mux4_rr_arbiter_if bus();

    mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; the expected value describes the outputs
    // after the following rising edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] dn,
                        input logic [3:0] eg, input logic [1:0] es, input logic eb,
                        input logic et, input string nm);
        exp_t e;
        @(negedge clk);
        rst     = r;
        bus.req = rq;
        bus.done = dn;
        e.name = nm;
        e.gnt  = eg;
        e.sel  = es;
        e.busy = eb;
        e.to   = et;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({bus.gnt, bus.sel, bus.busy, bus.timeout} !== {e.gnt, e.sel, e.busy, e.to}) begin
                    n_fail++;
                    $display("FAIL %s: got gnt=%b sel=%0d busy=%b timeout=%b, expected gnt=%b sel=%0d busy=%b timeout=%b",
                             e.name, bus.gnt, bus.sel, bus.busy, bus.timeout, e.gnt, e.sel, e.busy, e.to);
                end
            end
        end
    end

    initial begin : stimulus
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.req  = '0;
        bus.done = '0;

        //      rst   req      done     gnt      sel    busy  to
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "reset");
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_hold");

        // full request with done every cycle: 0,1,2,3,0 back-to-back
        step(1'b0, 4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0, "rr_g0");
        step(1'b0, 4'b1111, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0, "rr_g1");
        step(1'b0, 4'b1111, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0, "rr_g2");
        step(1'b0, 4'b1111, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0, "rr_g3");
        step(1'b0, 4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0, "rr_wrap0");
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_idle");

        // single request, then drop: sel keeps 2 in idle
        step(1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, "single_g2");
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "drop_idle_sel2");
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "idle_stays");

        // holder 1 releases while still requesting, 3 pending
        step(1'b0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, "g1");
        step(1'b0, 4'b0010, 4'b0001, 4'b0010, 2'd1, 1'b1, 1'b0, "done0_ignored");
        step(1'b0, 4'b1010, 4'b0010, 4'b1000, 2'd3, 1'b1, 1'b0, "rel1_to3");
        step(1'b0, 4'b1010, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0, "hold3");
        step(1'b0, 4'b1010, 4'b1000, 4'b0010, 2'd1, 1'b1, 1'b0, "regrant1");
        step(1'b0, 4'b1010, 4'b0010, 4'b1000, 2'd3, 1'b1, 1'b0, "g3_again");

        // reset mid-grant, then 1001 grants 0 first
        step(1'b1, 4'b1001, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rst_midgrant");
        step(1'b0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, "post_rst_g0");
        step(1'b0, 4'b1001, 4'b0001, 4'b1000, 2'd3, 1'b1, 1'b0, "post_rst_g3");
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, "idle_sel3");

        // releaser alone: goes idle, then re-granted from idle
        step(1'b0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, "solo_g0");
        step(1'b0, 4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0, "solo_rel_idle");
        step(1'b0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, "solo_regrant");
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "solo_idle");

`ifdef ARB_TIMEOUT_EN
        // holder 2 never releases; revoked after 4 cycles in favour of 0
        step(1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, "to_c1");
        step(1'b0, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, "to_c2");
        step(1'b0, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, "to_c3");
        step(1'b0, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, "to_c4");
        step(1'b0, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b1, "to_revoke");
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "to_pulse_end");
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
